mover_sequencer: RTL and testbench
==================================

# mover_sequencer

Round-robin scheduler sharing one `data_mover` instance among `NREQ` requesters. It accepts move requests (destination address), launches the mover with a one-cycle `start`, and tracks completion by counting write responses on the mover's destination B channel. When the move finishes it returns a per-requester done/error pulse. It sits between the host-side request logic and the `data_mover` `start`/`dest_address` inputs, and snoops `DST_AXI_B*`.

## Interface
- `NREQ`, 4, number of requesters (2..16)
- `BYTE_COUNT`, 1048576, bytes per move; must match the mover
- `BURST_SIZE`, 2048, bytes per burst; must match the mover
- `TIMEOUT_CYCLES`, 1048576, watchdog limit, idle cycles between B handshakes (used only with the watchdog macro)
- `clk`  in  1  single clock
- `resetn`  in  1  synchronous, active-low reset
- `req_valid`  in  NREQ  request pending per requester; held until `req_ready`
- `req_addr`  in  64*NREQ  destination address; requester i uses bits [64i+63:64i]
- `req_ready`  out  NREQ  one-cycle accept pulse, one-hot
- `done`  out  NREQ  one-cycle completion pulse, one-hot
- `done_err`  out  1  valid with `done`: 1 = zero address, nonzero BRESP, or timeout
- `mover_start`  out  1  one-cycle start pulse to the mover
- `mover_dest_address`  out  64  held stable from START until the next grant
- `mon_bvalid`, `mon_bready`  in  1 each  snoop of `DST_AXI_BVALID`/`BREADY`
- `mon_bresp`  in  2  snoop of `DST_AXI_BRESP`
- `busy`  out  1  high in every state except IDLE
- `active_id`  out  $clog2(NREQ)  index of the current or last grant
- `move_count`  out  32  successful moves since reset; wraps at 2^32
- `fault`  out  1  sticky watchdog fault (watchdog macro only; otherwise tied 0)

## Operation
- `BURSTS_PER_MOVE` = `BYTE_COUNT`/`BURST_SIZE`. B-handshake counter is 32 bits.
- **IDLE**
  - If any `req_valid` is set, the round-robin arbiter picks requester i, starting its search at `rr_ptr`.
  - Next cycle: `req_ready[i]`=1, `active_id`=i, `mover_dest_address` is latched, and the B counter and error flag are cleared.
  - If the address is nonzero, go to START. If it is 0, go to DONE with err=1; the mover ignores address 0, so no `mover_start` is issued.
- **START**: `mover_start`=1 for exactly one cycle, then go to WAIT.
- **WAIT**
  - Each cycle with `mon_bvalid & mon_bready` increments the counter.
  - A nonzero `mon_bresp` on any handshake sets the error flag.
  - When the counter reaches `BURSTS_PER_MOVE` on a handshake, go to DONE.
- **DONE**
  - `done[active_id]`=1 and `done_err`=error flag, for one cycle.
  - `move_count` increments only if err=0.
  - `rr_ptr` ← `active_id`+1 modulo `NREQ`. Return to IDLE.
- B handshakes outside WAIT are ignored. A `req_valid` that drops before `req_ready` is not tracked.
- Reset, including mid-move, clears all state. The mover is not aborted; the integrator resets both blocks together.

## Timing
- Reset values: `req_ready`=0, `done`=0, `done_err`=0, `mover_start`=0, `mover_dest_address`=0, `busy`=0, `active_id`=0, `move_count`=0, `fault`=0, `rr_ptr`=0, state=IDLE.
- All outputs are registered.
- Cycle map, with `req_valid` first seen in IDLE at edge N:
  - cycle N+1: `req_ready`
  - cycle N+2: `mover_start`
  - cycle after the final B handshake: `done`
- Zero-address request: `done` with err=1 appears two cycles after `req_ready`.
- Back-to-back throughput: minimum 3 cycles of overhead between the final B handshake of one move and the next `mover_start`.
- Simultaneous requests are resolved by the round-robin order. A requester that was just served has lowest priority next round.

## Configuration
- `MOVER_SEQ_WATCHDOG_EN` defined:
  - In WAIT, a cycle counter resets on each B handshake. When it reaches `TIMEOUT_CYCLES`, emit `done[active_id]` with err=1.
  - Then set `fault`=1 and enter FAULT state. FAULT is terminal: `busy`=1, no further grants, exit only by `resetn`. This exists because the mover cannot be aborted.
- Macro undefined: no watchdog counter, no FAULT state, `fault` tied 0, WAIT waits indefinitely.

## Structure
- Package `mover_pkg` holds:
  - the state enum (IDLE, START, WAIT, DONE, FAULT)
  - the `BURSTS_PER_MOVE` calculation function
  - the `BRESP_OKAY` constant
- Sub-module `rr_arbiter`, parameterized by `NREQ`: inputs request vector and pointer; outputs one-hot grant and index; purely combinational.

## Test plan
- Requester 1 alone, addr 0x1000_0000, BYTE_COUNT=8192, BURST_SIZE=2048, four OKAY B beats → `req_ready[1]` at N+1, `mover_start` at N+2, `done[1]` with err=0 one cycle after the fourth beat, `move_count`=1.
- All four requesters asserted together, repeatedly → grant order 0,1,2,3,0; each `done` precedes the next `req_ready`.
- Requester 2 with addr 0 → `req_ready[2]`, no `mover_start`, `done[2]` with err=1 two cycles later, `move_count` unchanged.
- Third B beat has BRESP=2'b10 → the move still completes after four beats, `done_err`=1, `move_count` unchanged.
- `resetn` low during WAIT after two beats, then a new request → all outputs at reset values, and the fresh move needs four new beats.
- With `MOVER_SEQ_WATCHDOG_EN` and TIMEOUT_CYCLES=100, B beats stop after beat 2 → `done` with err=1 at 100 idle cycles, `fault`=1, and later requests receive no `req_ready`.

Source files
------------

// File: rtl/mover_pkg.sv
// -----------------------------------------------------------------------------
// mover_pkg
//   Shared types and constants for the mover_sequencer block.
//   - state_t         : sequencer FSM encoding (IDLE, START, WAIT, DONE, FAULT)
//   - BRESP_OKAY      : AXI write-response code for a good beat
//   - bursts_per_move : number of B handshakes that make up one complete move
// -----------------------------------------------------------------------------
package mover_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [1:0] BRESP_OKAY = 2'b00;

    // One B response comes back per burst, so a move is finished once this
    // many handshakes have been seen on the destination B channel.
    function automatic logic [31:0] bursts_per_move(input int unsigned byte_count,
                                                    input int unsigned burst_size);
        return 32'(byte_count / burst_size);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin arbiter. The search for a pending
//   request starts at i_ptr and wraps around; the first hit wins.
//   Ports:
//     i_req   [NREQ-1:0] : request vector
//     i_ptr   [IDW-1:0]  : index where the search starts
//     o_grant [NREQ-1:0] : one-hot grant (all zero when nothing requests)
//     o_idx   [IDW-1:0]  : index of the granted requester
//     o_any              : at least one request is pending
// -----------------------------------------------------------------------------
module rr_arbiter
    import mover_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    int w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (!o_any) begin
                w_j = (int'(i_ptr) + k) % NREQ;
                if (i_req[w_j]) begin
                    o_grant[w_j] = 1'b1;
                    o_idx        = IDW'(w_j);
                    o_any        = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mover_sequencer.sv
// -----------------------------------------------------------------------------
// mover_sequencer
//   Shares one data_mover among NREQ requesters. A request (destination
//   address) is accepted round-robin, the mover is launched with a one-cycle
//   start pulse, and completion is tracked by counting write-response
//   handshakes snooped from the mover's destination B channel. A one-hot
//   done pulse (with error flag) is returned to the requester.
//
//   Optional feature: define MOVER_SEQ_WATCHDOG_EN to add a watchdog on the
//   gap between B handshakes. On expiry the requester gets done with error
//   and the block parks in a terminal FAULT state until reset, because the
//   mover itself cannot be aborted.
//
//   Handshake: req_valid[i] is held by requester i until it sees the
//   one-cycle req_ready[i] pulse; a valid that drops before then is simply
//   forgotten. done[i]/done_err form a one-cycle pulse with no back-pressure.
//
//   Ports:
//     clk, resetn              : clock, synchronous active-low reset
//     req_valid [NREQ]         : pending request per requester
//     req_addr  [64*NREQ]      : destination address, requester i at [64i+:64]
//     req_ready [NREQ]         : one-hot accept pulse
//     done      [NREQ]         : one-hot completion pulse
//     done_err                 : error qualifier for done
//     mover_start              : one-cycle start pulse to the mover
//     mover_dest_address [64]  : address presented to the mover
//     mon_bvalid/bready/bresp  : snoop of the mover's DST_AXI_B channel
//     busy                     : high whenever the FSM is not idle
//     active_id                : index of the current or last grant
//     move_count [32]          : error-free moves since reset (wraps)
//     fault                    : sticky watchdog fault (0 without watchdog)
//     dbg_state [3]            : current FSM state encoding
// -----------------------------------------------------------------------------
module mover_sequencer
    import mover_pkg::*;
#(
    parameter  int NREQ           = 4,
    parameter  int BYTE_COUNT     = 1048576,
    parameter  int BURST_SIZE     = 2048,
    parameter  int TIMEOUT_CYCLES = 1048576,
    localparam int IDW            = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [64*NREQ-1:0]   req_addr,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      done,
    output logic                 done_err,
    output logic                 mover_start,
    output logic [63:0]          mover_dest_address,
    input  logic                 mon_bvalid,
    input  logic                 mon_bready,
    input  logic [1:0]           mon_bresp,
    output logic                 busy,
    output logic [IDW-1:0]       active_id,
    output logic [31:0]          move_count,
    output logic                 fault,
    output logic [2:0]           dbg_state
);

    localparam logic [31:0] BURSTS = bursts_per_move(BYTE_COUNT, BURST_SIZE);

    // Elaboration-time sanity check on the configuration.
    if (NREQ < 2 || NREQ > 16 || BURST_SIZE <= 0 || BYTE_COUNT < BURST_SIZE ||
        (BYTE_COUNT % BURST_SIZE) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("mover_sequencer: illegal parameter combination");
    end

    state_t              r_state;
    state_t              w_state_next;

    logic [NREQ-1:0]     w_grant;
    logic [IDW-1:0]      w_idx;
    logic                w_any;
    logic [63:0]         w_addr;

    logic [IDW-1:0]      r_rr_ptr;
    logic [IDW-1:0]      r_active_id;
    logic [63:0]         r_dest;
    logic [31:0]         r_bcnt;
    logic                r_err;
    logic                r_zero;
    logic [NREQ-1:0]     r_req_ready;
    logic [NREQ-1:0]     r_done;
    logic                r_done_err;
    logic                r_start;
    logic                r_busy;
    logic [31:0]         r_move_count;

    logic                w_hs;
    logic                w_beat_err;
    logic [31:0]         w_bcnt_inc;
    logic                w_last;

`ifdef MOVER_SEQ_WATCHDOG_EN
    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);
    logic [31:0]         r_wdog;
    logic                r_fault;
    logic                w_timeout;
`endif

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_addr     = req_addr[64*int'(w_idx) +: 64];
    assign w_hs       = mon_bvalid & mon_bready;
    assign w_beat_err = w_hs && (mon_bresp != BRESP_OKAY);
    assign w_bcnt_inc = r_bcnt + 32'd1;
    assign w_last     = w_hs && (w_bcnt_inc == BURSTS);

`ifdef MOVER_SEQ_WATCHDOG_EN
    // Watchdog counts WAIT cycles without a handshake; it fires on the cycle
    // that would make the idle run reach TIMEOUT_CYCLES.
    assign w_timeout = !w_hs && (r_wdog == TIMEOUT_LIM - 32'd1);
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    // A zero-address request walks START and WAIT with the start pulse gated
    // off, so its done pulse lands two cycles after the accept.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_any) w_state_next = ST_START;
            ST_START: w_state_next = ST_WAIT;
            ST_WAIT: begin
                if (r_zero || w_last) begin
                    w_state_next = ST_DONE;
                end
`ifdef MOVER_SEQ_WATCHDOG_EN
                else if (w_timeout) begin
                    w_state_next = ST_FAULT;
                end
`endif
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = r_state;
        endcase
    end

    // ---------------- registered datapath and outputs ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rr_ptr     <= '0;
            r_active_id  <= '0;
            r_dest       <= '0;
            r_bcnt       <= '0;
            r_err        <= 1'b0;
            r_zero       <= 1'b0;
            r_req_ready  <= '0;
            r_done       <= '0;
            r_done_err   <= 1'b0;
            r_start      <= 1'b0;
            r_busy       <= 1'b0;
            r_move_count <= '0;
`ifdef MOVER_SEQ_WATCHDOG_EN
            r_wdog       <= '0;
            r_fault      <= 1'b0;
`endif
        end else begin
            r_req_ready <= '0;
            r_done      <= '0;
            r_done_err  <= 1'b0;
            r_start     <= 1'b0;
            r_busy      <= (w_state_next != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_req_ready <= w_grant;
                        r_active_id <= w_idx;
                        r_dest      <= w_addr;
                        r_bcnt      <= '0;
                        r_zero      <= (w_addr == 64'd0);
                        r_err       <= (w_addr == 64'd0);
`ifdef MOVER_SEQ_WATCHDOG_EN
                        r_wdog      <= '0;
`endif
                    end
                end
                ST_START: begin
                    r_start <= !r_zero;
                end
                ST_WAIT: begin
                    if (w_hs) begin
                        r_bcnt <= w_bcnt_inc;
                        if (w_beat_err) begin
                            r_err <= 1'b1;
                        end
                    end
                    // The final beat's BRESP must reach done_err directly,
                    // since r_err only picks it up on this same edge.
                    if (w_state_next == ST_DONE) begin
                        r_done[r_active_id] <= 1'b1;
                        r_done_err          <= r_err | w_beat_err;
                    end
`ifdef MOVER_SEQ_WATCHDOG_EN
                    if (w_hs) begin
                        r_wdog <= '0;
                    end else begin
                        r_wdog <= r_wdog + 32'd1;
                    end
                    if (w_state_next == ST_FAULT) begin
                        r_done[r_active_id] <= 1'b1;
                        r_done_err          <= 1'b1;
                        r_fault             <= 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    if (!r_err) begin
                        r_move_count <= r_move_count + 32'd1;
                    end
                    // Just-served requester drops to lowest priority.
                    r_rr_ptr <= (r_active_id == IDW'(NREQ - 1)) ? '0 : r_active_id + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready          = r_req_ready;
    assign done               = r_done;
    assign done_err           = r_done_err;
    assign mover_start        = r_start;
    assign mover_dest_address = r_dest;
    assign busy               = r_busy;
    assign active_id          = r_active_id;
    assign move_count         = r_move_count;
    assign dbg_state          = r_state;

`ifdef MOVER_SEQ_WATCHDOG_EN
    assign fault = r_fault;
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_mover_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mover_sequencer
//   Directed bench for mover_sequencer with NREQ=4, BYTE_COUNT=8192,
//   BURST_SIZE=2048 (four B beats per move) and TIMEOUT_CYCLES=100.
//   The watchdog scenario is compiled in when MOVER_SEQ_WATCHDOG_EN is set.
// -----------------------------------------------------------------------------
module tb_mover_sequencer;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                resetn;
    logic [NREQ-1:0]     req_valid;
    logic [64*NREQ-1:0]  req_addr;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     done;
    logic                done_err;
    logic                mover_start;
    logic [63:0]         mover_dest_address;
    logic                mon_bvalid;
    logic                mon_bready;
    logic [1:0]          mon_bresp;
    logic                busy;
    logic [IDW-1:0]      active_id;
    logic [31:0]         move_count;
    logic                fault;
    logic [2:0]          dbg_state;

    mover_sequencer #(
        .NREQ           (NREQ),
        .BYTE_COUNT     (8192),
        .BURST_SIZE     (2048),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk                (clk),
        .resetn             (resetn),
        .req_valid          (req_valid),
        .req_addr           (req_addr),
        .req_ready          (req_ready),
        .done               (done),
        .done_err           (done_err),
        .mover_start        (mover_start),
        .mover_dest_address (mover_dest_address),
        .mon_bvalid         (mon_bvalid),
        .mon_bready         (mon_bready),
        .mon_bresp          (mon_bresp),
        .busy               (busy),
        .active_id          (active_id),
        .move_count         (move_count),
        .fault              (fault),
        .dbg_state          (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [NREQ-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one clock and land 1ns after the edge: outputs are stable there
    // and new inputs are set up well before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [63:0] a);
        req_addr[64*i +: 64] = a;
    endtask

    task automatic beat(input logic [1:0] resp);
        mon_bvalid = 1'b1;
        mon_bready = 1'b1;
        mon_bresp  = resp;
        tick();
        mon_bvalid = 1'b0;
        mon_bready = 1'b0;
        mon_bresp  = 2'b00;
    endtask

    task automatic wait_ready(input int budget, output int n);
        n = -1;
        for (int c = 1; c <= budget; c++) begin
            tick();
            if (req_ready != '0) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output int n);
        n = -1;
        for (int c = 1; c <= budget; c++) begin
            tick();
            if (done != '0) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'h0);
        chk({tag, "_done"}, 64'(done), 64'h0);
        chk({tag, "_done_err"}, 64'(done_err), 64'h0);
        chk({tag, "_start"}, 64'(mover_start), 64'h0);
        chk({tag, "_dest"}, mover_dest_address, 64'h0);
        chk({tag, "_busy"}, 64'(busy), 64'h0);
        chk({tag, "_active_id"}, 64'(active_id), 64'h0);
        chk({tag, "_move_count"}, 64'(move_count), 64'h0);
        chk({tag, "_fault"}, 64'(fault), 64'h0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        logic [NREQ-1:0] exp_grant;
        int exp_id;

        resetn     = 1'b0;
        req_valid  = '0;
        req_addr   = '0;
        mon_bvalid = 1'b0;
        mon_bready = 1'b0;
        mon_bresp  = 2'b00;
        repeat (3) tick();
        chk_reset_values("rst");
        resetn = 1'b1;
        tick();

        // --- requester 1 alone, four OKAY beats ---
        set_addr(1, 64'h1000_0000);
        req_valid = 4'b0010;
        tick();
        chk("r1_ready", 64'(req_ready), 64'h2);
        chk("r1_active", 64'(active_id), 64'h1);
        chk("r1_busy", 64'(busy), 64'h1);
        chk("r1_no_early_start", 64'(mover_start), 64'h0);
        req_valid = '0;
        tick();
        chk("r1_start", 64'(mover_start), 64'h1);
        chk("r1_ready_pulse", 64'(req_ready), 64'h0);
        chk("r1_dest", mover_dest_address, 64'h1000_0000);
        beat(2'b00);
        chk("r1_start_once", 64'(mover_start), 64'h0);
        beat(2'b00);
        beat(2'b00);
        chk("r1_not_done_3", 64'(done), 64'h0);
        beat(2'b00);
        chk("r1_done", 64'(done), 64'h2);
        chk("r1_done_err", 64'(done_err), 64'h0);
        tick();
        chk("r1_done_pulse", 64'(done), 64'h0);
        chk("r1_count", 64'(move_count), 64'h1);
        chk("r1_idle", 64'(busy), 64'h0);

        // --- requester 2 with zero address ---
        set_addr(2, 64'h0);
        req_valid = 4'b0100;
        tick();
        chk("z_ready", 64'(req_ready), 64'h4);
        req_valid = '0;
        tick();
        chk("z_no_start", 64'(mover_start), 64'h0);
        chk("z_not_done_yet", 64'(done), 64'h0);
        tick();
        chk("z_done", 64'(done), 64'h4);
        chk("z_done_err", 64'(done_err), 64'h1);
        tick();
        chk("z_count", 64'(move_count), 64'h1);

        // --- requester 3, third beat SLVERR ---
        set_addr(3, 64'h4000_0000);
        req_valid = 4'b1000;
        tick();
        chk("e_ready", 64'(req_ready), 64'h8);
        req_valid = '0;
        tick();
        chk("e_start", 64'(mover_start), 64'h1);
        beat(2'b00);
        beat(2'b00);
        beat(2'b10);
        chk("e_not_done_3", 64'(done), 64'h0);
        beat(2'b00);
        chk("e_done", 64'(done), 64'h8);
        chk("e_done_err", 64'(done_err), 64'h1);
        tick();
        chk("e_count", 64'(move_count), 64'h1);

        // --- all four requesting: grant order 0,1,2,3,0 ---
        for (int i = 0; i < NREQ; i++) set_addr(i, 64'h2000_0000 + 64'(i) * 64'h100);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_grant = exp_q.pop_front();
            exp_id = (k == 4) ? 0 : k;
            wait_ready(10, n);
            chk("rr_ready_latency", 64'(n), (k == 0) ? 64'd1 : 64'd2);
            chk("rr_grant", 64'(req_ready), 64'(exp_grant));
            chk("rr_active", 64'(active_id), 64'(exp_id));
            tick();
            chk("rr_start", 64'(mover_start), 64'h1);
            chk("rr_dest", mover_dest_address, 64'h2000_0000 + 64'(exp_id) * 64'h100);
            repeat (3) beat(2'b00);
            beat(2'b00);
            chk("rr_done", 64'(done), 64'(exp_grant));
            chk("rr_done_err", 64'(done_err), 64'h0);
            if (k == 4) req_valid = '0;
        end
        tick();
        chk("rr_count", 64'(move_count), 64'd6);

        // --- reset in the middle of a move ---
        set_addr(1, 64'h3000_0000);
        req_valid = 4'b0010;
        tick();
        chk("mr_ready", 64'(req_ready), 64'h2);
        req_valid = '0;
        tick();
        beat(2'b00);
        beat(2'b00);
        resetn = 1'b0;
        tick();
        chk_reset_values("mr");
        resetn = 1'b1;
        tick();
        set_addr(2, 64'h5000_0000);
        req_valid = 4'b0100;
        tick();
        chk("mr2_ready", 64'(req_ready), 64'h4);
        chk("mr2_active", 64'(active_id), 64'h2);
        req_valid = '0;
        tick();
        chk("mr2_start", 64'(mover_start), 64'h1);
        chk("mr2_dest", mover_dest_address, 64'h5000_0000);
        repeat (3) beat(2'b00);
        chk("mr2_not_done_3", 64'(done), 64'h0);
        beat(2'b00);
        chk("mr2_done", 64'(done), 64'h4);
        tick();
        chk("mr2_count", 64'(move_count), 64'h1);

`ifdef MOVER_SEQ_WATCHDOG_EN
        // --- watchdog: beats stop after beat 2 ---
        set_addr(3, 64'h6000_0000);
        req_valid = 4'b1000;
        tick();
        chk("wd_ready", 64'(req_ready), 64'h8);
        req_valid = '0;
        tick();
        beat(2'b00);
        beat(2'b00);
        wait_done(200, n);
        chk("wd_latency", 64'(n), 64'd100);
        chk("wd_done", 64'(done), 64'h8);
        chk("wd_done_err", 64'(done_err), 64'h1);
        chk("wd_fault", 64'(fault), 64'h1);
        set_addr(0, 64'h7000_0000);
        req_valid = 4'b0001;
        wait_ready(8, n);
        chk("wd_no_grant", 64'(n), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wd_busy", 64'(busy), 64'h1);
        chk("wd_fault_sticky", 64'(fault), 64'h1);
        chk("wd_count", 64'(move_count), 64'h1);
        req_valid = '0;
`else
        chk("nowd_fault", 64'(fault), 64'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
